// File: rtl/rs2_port_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the rs2 read-port arbiter.
package rs2_arb_pkg;

  localparam int DW   = 16;
  localparam int NREQ = 4;
  localparam int IXW  = 4;
  localparam int IDW  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Converts a requester id into its one-hot strobe position.
  function automatic logic [NREQ-1:0] id2onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rs2_port_arbiter_if.sv
// Requester / decode-unit bundle seen by the rs2 read-port arbiter.
// The slave modport is the arbiter's view, master is the surrounding system.
interface rs2_port_arbiter_if #(parameter int DW = rs2_arb_pkg::DW);
  import rs2_arb_pkg::*;

  logic [NREQ-1:0]     req;
  logic [NREQ*IXW-1:0] idx;
  logic                port_busy;
  logic [DW-1:0]       rs2_data;
  logic [IXW-1:0]      rs2_o;
  logic [IDW-1:0]      f0_o;
  logic                port_en;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     rvalid;
  logic [NREQ*DW-1:0]  rdata;

  modport slave (
    input  req, idx, port_busy, rs2_data,
    output rs2_o, f0_o, port_en, grant, rvalid, rdata
  );

  modport master (
    output req, idx, port_busy, rs2_data,
    input  rs2_o, f0_o, port_en, grant, rvalid, rdata
  );

endinterface

// File: rtl/rs2_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping,
// reporting whether anyone is requesting and which requester is first.
module rr_pick4 import rs2_arb_pkg::*; (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  id
);

  logic [IDW-1:0] w_cand;

  // Walk from the farthest offset back to ptr so the closest hit is kept last.
  always_comb begin
    any    = 1'b0;
    id     = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = ptr + IDW'(k);
      if (req[w_cand]) begin
        any = 1'b1;
        id  = w_cand;
      end
    end
  end

endmodule

// File: rtl/rs2_port_arbiter.sv
// Shares the decode unit's rs2 read port among four requesters. One
// transaction is IDLE (arbitrate) -> READ (drive port, grant) -> RESP
// (rvalid pulse), with a round-robin pointer advanced past each winner.
module rs2_port_arbiter #(parameter int DW = rs2_arb_pkg::DW) (
  input logic               clk,
  input logic               rst,
  rs2_port_arbiter_if.slave bus
);
  import rs2_arb_pkg::*;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_winId;
  logic [IXW-1:0]     r_winIdx;
  logic [NREQ*DW-1:0] r_rdata;
  logic               w_any;
  logic [IDW-1:0]     w_pickId;
  logic               w_launch;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_any),
    .id  (w_pickId)
  );

  // A transaction starts only from IDLE, with a requester and a free port.
  assign w_launch = (r_state == IDLE) && w_any && !bus.port_busy;

  // State register; reset drops any in-flight transaction back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: READ and RESP each last exactly one cycle.
  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = w_launch ? READ : IDLE;
      READ:    w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Winner latch, response data capture and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_winId  <= '0;
      r_winIdx <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_launch) begin
        r_winId  <= w_pickId;
        r_winIdx <= bus.idx[IXW*w_pickId +: IXW];
      end
      if (r_state == READ) begin
        r_rdata[DW*r_winId +: DW] <= bus.rs2_data;
      end
      if (r_state == RESP) begin
        r_ptr <= r_winId + 1'b1;
      end
    end
  end

  // Port drive and strobes are decoded from the state so they are quiet elsewhere.
  always_comb begin
    bus.port_en = 1'b0;
    bus.rs2_o   = '0;
    bus.f0_o    = '0;
    bus.grant   = '0;
    bus.rvalid  = '0;
    case (r_state)
      READ: begin
        bus.port_en = 1'b1;
        bus.rs2_o   = r_winIdx;
        bus.f0_o    = r_winId;
        bus.grant   = id2onehot(r_winId);
      end
      RESP: begin
        bus.rvalid = id2onehot(r_winId);
      end
      default: begin
      end
    endcase
  end

  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_rs2_port_arbiter.sv
// Self-checking bench for rs2_port_arbiter: scenario tasks push expected
// transactions into a scoreboard; a per-cycle monitor pops them on grant.
module tb_rs2_port_arbiter;
  import rs2_arb_pkg::*;

  localparam int TDW = 16;

  typedef struct {
    int          id;
    logic [3:0]  idx;
    logic [15:0] data;
    int          cyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rs2_port_arbiter_if #(.DW(TDW)) bus();

  rs2_port_arbiter #(.DW(TDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Decode-unit model: register file read is combinational on rs2_o.
  logic [15:0] regFile [16];
  always_comb bus.rs2_data = regFile[bus.rs2_o];

  txn_t        sb[$];
  txn_t        pend;
  bit          pendValid = 1'b0;
  bit          rstAtLastNeg = 1'b1;
  logic [63:0] shadow = '0;
  int          testsRun = 0;
  int          testsFailed = 0;

  function automatic txn_t mk(input int id, input int ix, input int cyc);
    txn_t t;
    t.id   = id;
    t.idx  = 4'(ix);
    t.data = regFile[ix];
    t.cyc  = cyc;
    return t;
  endfunction

  // Per-cycle observation at the falling edge.
  task automatic monitorCycle();
    txn_t       t;
    logic [3:0] expRvalid;
    logic [3:0] expGrant;
    expRvalid = '0;
    if (rstAtLastNeg) begin
      pendValid = 1'b0;
      shadow    = '0;
    end else if (pendValid) begin
      expRvalid = 4'b0001 << pend.id;
      shadow[16*pend.id +: 16] = pend.data;
      pendValid = 1'b0;
    end
    testsRun++;
    if (bus.rvalid !== expRvalid) begin
      testsFailed++;
      $display("[TB] FAIL rvalid cyc %0d: got %b expected %b", cycleCnt, bus.rvalid, expRvalid);
    end
    testsRun++;
    if (bus.rdata !== shadow) begin
      testsFailed++;
      $display("[TB] FAIL rdata cyc %0d: got %h expected %h", cycleCnt, bus.rdata, shadow);
    end
    testsRun++;
    if (!$onehot0(bus.grant)) begin
      testsFailed++;
      $display("[TB] FAIL grant_onehot cyc %0d: got %b expected one-hot or zero", cycleCnt, bus.grant);
    end
    testsRun++;
    if (!$onehot0(bus.rvalid)) begin
      testsFailed++;
      $display("[TB] FAIL rvalid_onehot cyc %0d: got %b expected one-hot or zero", cycleCnt, bus.rvalid);
    end
    if (bus.grant !== 4'b0000) begin
      testsRun++;
      if (sb.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_grant cyc %0d: got %b expected 0000", cycleCnt, bus.grant);
      end else begin
        t = sb.pop_front();
        expGrant = 4'b0001 << t.id;
        if (bus.grant !== expGrant || bus.rs2_o !== t.idx || bus.f0_o !== 2'(t.id) ||
            bus.port_en !== 1'b1 || cycleCnt != t.cyc) begin
          testsFailed++;
          $display("[TB] FAIL grant_txn: got grant=%b rs2_o=%h f0_o=%0d port_en=%b cyc=%0d expected grant=%b rs2_o=%h f0_o=%0d port_en=1 cyc=%0d",
                   bus.grant, bus.rs2_o, bus.f0_o, bus.port_en, cycleCnt, expGrant, t.idx, t.id, t.cyc);
        end
        pend      = t;
        pendValid = 1'b1;
      end
    end else begin
      testsRun++;
      if (bus.port_en !== 1'b0 || bus.rs2_o !== 4'h0 || bus.f0_o !== 2'd0) begin
        testsFailed++;
        $display("[TB] FAIL idle_outputs cyc %0d: got port_en=%b rs2_o=%h f0_o=%0d expected all 0",
                 cycleCnt, bus.port_en, bus.rs2_o, bus.f0_o);
      end
    end
    rstAtLastNeg = rst;
  endtask

  // One clock: observe at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitorCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrants(input int budget, input string name);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL %s_timeout: got %0d grants outstanding expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    for (int i = 0; i < budget && pendValid; i++) tick();
    testsRun++;
    if (pendValid) begin
      testsFailed++;
      $display("[TB] FAIL %s_rvalid_timeout: got response pending expected none", name);
      pendValid = 1'b0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.idx = '0;
    bus.port_busy = 1'b0;
    tick();
    tick();
    testsRun++;
    if (bus.grant !== 4'b0 || bus.rvalid !== 4'b0 || bus.port_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_strobes: got grant=%b rvalid=%b port_en=%b expected 0", bus.grant, bus.rvalid, bus.port_en);
    end
    testsRun++;
    if (bus.rs2_o !== 4'h0 || bus.f0_o !== 2'd0 || bus.rdata !== 64'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got rs2_o=%h f0_o=%0d rdata=%h expected 0", bus.rs2_o, bus.f0_o, bus.rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    bus.idx = 16'h0005;
    sb.push_back(mk(0, 5, cycleCnt + 1));
    waitGrants(10, "single");
    bus.req = 4'b0000;
    waitIdle(10, "single");
    testsRun++;
    if (bus.rdata[15:0] !== 16'hA5A5) begin
      testsFailed++;
      $display("[TB] FAIL single_rdata: got %h expected a5a5", bus.rdata[15:0]);
    end
  endtask

  task automatic test_round_robin();
    int base;
    doReset();
    bus.req = 4'b1111;
    bus.idx = 16'h4321;
    base = cycleCnt;
    for (int k = 0; k < 5; k++) sb.push_back(mk(k % 4, (k % 4) + 1, base + 1 + 3 * k));
    waitGrants(40, "round_robin");
    bus.req = 4'b0000;
    waitIdle(10, "round_robin");
    for (int n = 0; n < 4; n++) begin
      testsRun++;
      if (bus.rdata[16*n +: 16] !== regFile[n + 1]) begin
        testsFailed++;
        $display("[TB] FAIL rr_slice%0d: got %h expected %h", n, bus.rdata[16*n +: 16], regFile[n + 1]);
      end
    end
  endtask

  task automatic test_busy();
    bus.port_busy = 1'b1;
    bus.req = 4'b0100;
    bus.idx = 16'h0700;
    for (int k = 0; k < 5; k++) begin
      tick();
      testsRun++;
      if (bus.grant !== 4'b0 || bus.port_en !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL busy_hold: got grant=%b port_en=%b expected 0000/0", bus.grant, bus.port_en);
      end
    end
    bus.port_busy = 1'b0;
    sb.push_back(mk(2, 7, cycleCnt + 1));
    waitGrants(10, "busy");
    bus.req = 4'b0000;
    waitIdle(10, "busy");
  endtask

  task automatic test_fairness();
    int base;
    bus.req = 4'b1001;
    bus.idx = 16'h9006;
    base = cycleCnt;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) sb.push_back(mk(3, 9, base + 1 + 3 * k));
      else            sb.push_back(mk(0, 6, base + 1 + 3 * k));
    end
    waitGrants(60, "fairness");
    bus.req = 4'b0000;
    waitIdle(10, "fairness");
    testsRun++;
    if (bus.rdata !== {regFile[9], regFile[7], regFile[2], regFile[6]}) begin
      testsFailed++;
      $display("[TB] FAIL fairness_rdata: got %h expected %h", bus.rdata, {regFile[9], regFile[7], regFile[2], regFile[6]});
    end
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0010;
    bus.idx = 16'h00A0;
    sb.push_back(mk(1, 10, cycleCnt + 1));
    tick();
    rst = 1'b1;
    tick();
    testsRun++;
    if (bus.rvalid !== 4'b0 || bus.grant !== 4'b0 || bus.port_en !== 1'b0 ||
        bus.rs2_o !== 4'h0 || bus.f0_o !== 2'd0 || bus.rdata !== 64'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got rvalid=%b grant=%b port_en=%b rs2_o=%h f0_o=%0d rdata=%h expected all 0",
               bus.rvalid, bus.grant, bus.port_en, bus.rs2_o, bus.f0_o, bus.rdata);
    end
    rst = 1'b0;
    sb.push_back(mk(1, 10, cycleCnt + 1));
    waitGrants(10, "reset_mid");
    bus.req = 4'b0000;
    waitIdle(10, "reset_mid");
    testsRun++;
    if (bus.rdata !== {32'h0, regFile[10], 16'h0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_rdata: got %h expected %h", bus.rdata, {32'h0, regFile[10], 16'h0});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regFile[i] = 16'(i * 16'h1357 + 16'h0042);
    regFile[5] = 16'hA5A5;
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_fairness();
    test_reset_mid();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
